adam_axil_mem_resp: RTL and testbench

ADAM_AXIL_MEM_RESP -- requirements
Module: adam_axil_mem_resp

---
 rtl/adam_axil_mem_resp.sv | 170 +++++++++++++++++
 tb/tb_adam_axil_mem_resp.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_axil_mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adam_axil_mem_resp: AXI-Lite slave fronting a single-port SRAM,          |
// | one transaction in flight, round-robin write/read arbitration.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adam_axil_mem_resp #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [ADDR_WIDTH-1:0]         aw_addr,
   input  logic                          aw_valid,
   output logic                          aw_ready,
   input  logic [DATA_WIDTH-1:0]         w_data,
   input  logic [STRB_WIDTH-1:0]         w_strb,
   input  logic                          w_valid,
   output logic                          w_ready,
   output logic [1:0]                    b_resp,
   output logic                          b_valid,
   input  logic                          b_ready,
   input  logic [ADDR_WIDTH-1:0]         ar_addr,
   input  logic                          ar_valid,
   output logic                          ar_ready,
   output logic [DATA_WIDTH-1:0]         r_data,
   output logic [1:0]                    r_resp,
   output logic                          r_valid,
   input  logic                          r_ready,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr_o,
   output logic [STRB_WIDTH-1:0]         mem_be_o,
   output logic [DATA_WIDTH-1:0]         mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

   localparam int c_off_w = $clog2(STRB_WIDTH);
   localparam int c_mem_aw = $clog2(MEM_DEPTH);
   localparam int c_idx_w = ADDR_WIDTH - c_off_w;
   localparam logic [1:0] c_resp_okay = 2'b00;
   localparam logic [1:0] c_resp_slverr = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_RDATA = 3'd3,
      S_BRESP = 3'd4,
      S_RRESP = 3'd5
   } state_t;

   state_t r_state;
   logic   r_rr_wr;   // 1: write wins a tie on the next arbitration

   logic [c_idx_w-1:0] w_aw_idx;
   logic [c_idx_w-1:0] w_ar_idx;
   logic               w_aw_in_range;
   logic               w_ar_in_range;
   logic               w_wr_pend;
   logic               w_grant_wr;
   logic               w_grant_rd;
   logic               w_idle;
   logic               w_unused;

   assign w_aw_idx      = aw_addr[ADDR_WIDTH-1:c_off_w];
   assign w_ar_idx      = ar_addr[ADDR_WIDTH-1:c_off_w];
   assign w_aw_in_range = (w_aw_idx >> c_mem_aw) == '0;
   assign w_ar_in_range = (w_ar_idx >> c_mem_aw) == '0;
   assign w_unused      = ^{aw_addr[c_off_w-1:0], ar_addr[c_off_w-1:0]};

   // A write is only pending once both AW and W are presented.
   assign w_wr_pend  = aw_valid && w_valid;
   assign w_grant_wr = w_wr_pend && (!ar_valid || r_rr_wr);
   assign w_grant_rd = ar_valid && !w_grant_wr;
   assign w_idle     = (r_state == S_IDLE);

   assign aw_ready = w_idle && w_grant_wr;
   assign w_ready  = w_idle && w_grant_wr;
   assign ar_ready = w_idle && w_grant_rd;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_rr_wr     <= 1'b1;
         b_valid     <= 1'b0;
         b_resp      <= c_resp_okay;
         r_valid     <= 1'b0;
         r_resp      <= c_resp_okay;
         r_data      <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
      end else begin
         // SRAM strobe lasts exactly one cycle; idle values are all zero.
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_wr) begin
                  r_rr_wr <= 1'b0;
                  if (w_aw_in_range) begin
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= 1'b1;
                     mem_addr_o  <= w_aw_idx[c_mem_aw-1:0];
                     mem_be_o    <= w_strb;
                     mem_wdata_o <= w_data;
                     r_state     <= S_WRITE;
                  end else begin
                     b_valid <= 1'b1;
                     b_resp  <= c_resp_slverr;
                     r_state <= S_BRESP;
                  end
               end else if (w_grant_rd) begin
                  r_rr_wr <= 1'b1;
                  if (w_ar_in_range) begin
                     mem_req_o  <= 1'b1;
                     mem_addr_o <= w_ar_idx[c_mem_aw-1:0];
                     r_state    <= S_READ;
                  end else begin
                     r_valid <= 1'b1;
                     r_resp  <= c_resp_slverr;
                     r_data  <= '0;
                     r_state <= S_RRESP;
                  end
               end
            end
            S_WRITE: begin
               b_valid <= 1'b1;
               b_resp  <= c_resp_okay;
               r_state <= S_BRESP;
            end
            S_READ: begin
               r_state <= S_RDATA;
            end
            S_RDATA: begin
               r_data  <= mem_rdata_i;
               r_resp  <= c_resp_okay;
               r_valid <= 1'b1;
               r_state <= S_RRESP;
            end
            S_BRESP: begin
               if (b_ready) begin
                  b_valid <= 1'b0;
                  b_resp  <= c_resp_okay;
                  r_state <= S_IDLE;
               end
            end
            S_RRESP: begin
               if (r_ready) begin
                  r_valid <= 1'b0;
                  r_resp  <= c_resp_okay;
                  r_data  <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adam_axil_mem_resp.sv
`default_nettype none
// Scoreboard bench for adam_axil_mem_resp: directed vectors push expected
// responses; a negedge monitor pops and compares when b_valid/r_valid rise.
module tb_adam_axil_mem_resp;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic [AW-1:0] aw_addr = '0;
   logic          aw_valid = 1'b0;
   logic          aw_ready;
   logic [DW-1:0] w_data = '0;
   logic [3:0]    w_strb = '0;
   logic          w_valid = 1'b0;
   logic          w_ready;
   logic [1:0]    b_resp;
   logic          b_valid;
   logic          b_ready = 1'b1;
   logic [AW-1:0] ar_addr = '0;
   logic          ar_valid = 1'b0;
   logic          ar_ready;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_valid;
   logic          r_ready = 1'b1;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [9:0]    mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;

   always #5 clk = ~clk;

   adam_axil_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // SRAM model: byte-enabled write, one-cycle read latency.
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= mem[mem_addr_o];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          t;
      int          lat;
   } exp_t;

   exp_t bq[$];
   exp_t rq[$];

   // Monitor
   logic prev_b = 1'b0;
   logic prev_r = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (b_valid && !prev_b) begin
         if (bq.size() == 0) chk("b_unexpected", 64'(b_valid), 64'(0));
         else begin
            me = bq.pop_front();
            chk("b_resp", 64'(b_resp), 64'(me.resp));
            chk("b_latency", 64'(cyc - me.t), 64'(me.lat));
         end
      end
      if (r_valid && !prev_r) begin
         if (rq.size() == 0) chk("r_unexpected", 64'(r_valid), 64'(0));
         else begin
            me = rq.pop_front();
            chk("r_resp", 64'(r_resp), 64'(me.resp));
            chk("r_data", 64'(r_data), 64'(me.data));
            chk("r_latency", 64'(cyc - me.t), 64'(me.lat));
         end
      end
      if (!mem_req_o)
         chk("mem_idle_zero", 64'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(0));
      prev_b = b_valid;
      prev_r = r_valid;
   end

   task automatic wait_accept(output int which, output int t);
      bit got;
      got = 1'b0;
      which = -1;
      t = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (aw_ready || ar_ready) begin
            which = ar_ready ? 1 : 0;
            t = cyc;
            got = 1'b1;
         end
      end
      if (!got) chk("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic push_b(input logic [1:0] resp, input int t, input int lat);
      exp_t e;
      e.resp = resp; e.data = '0; e.t = t; e.lat = lat;
      bq.push_back(e);
   endtask

   task automatic push_r(input logic [1:0] resp, input logic [31:0] data, input int t, input int lat);
      exp_t e;
      e.resp = resp; e.data = data; e.t = t; e.lat = lat;
      rq.push_back(e);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int lat);
      int which, t;
      @(posedge clk); #1;
      aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1;
      wait_accept(which, t);
      chk("write_granted", 64'(which), 64'(0));
      push_b(resp, t, lat);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      if (resp == 2'b00) begin
         chk("wr_mem_ctrl", 64'({mem_req_o, mem_we_o, mem_be_o}), 64'({2'b11, strb}));
         chk("wr_mem_addr", 64'(mem_addr_o), 64'(addr[11:2]));
         chk("wr_mem_wdata", 64'(mem_wdata_o), 64'(data));
      end else begin
         chk("wr_oor_no_req", 64'(mem_req_o), 64'(0));
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int lat);
      int which, t;
      bit seen;
      @(posedge clk); #1;
      ar_addr = addr; ar_valid = 1'b1;
      wait_accept(which, t);
      chk("read_granted", 64'(which), 64'(1));
      push_r(resp, data, t, lat);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      if (resp == 2'b00) begin
         @(negedge clk);
         chk("rd_mem_ctrl", 64'({mem_req_o, mem_we_o}), 64'(2'b10));
         chk("rd_mem_addr", 64'(mem_addr_o), 64'(addr[11:2]));
      end else begin
         seen = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (mem_req_o) seen = 1'b1;
         end
         chk("rd_oor_no_req", 64'(seen), 64'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int which, t;
      bit ok;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", 64'({b_valid, r_valid}), 64'(0));
      chk("rst_readies", 64'({aw_ready, w_ready, ar_ready}), 64'(0));
      chk("rst_mem", 64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}), 64'(0));
      chk("rst_rdata_resp", 64'({r_data, b_resp, r_resp}), 64'(0));
      @(posedge clk); #1;
      rst_ni = 1'b1;

      // Round-robin: write wins out of reset, then read wins the next tie
      @(posedge clk); #1;
      aw_addr = 32'h20; w_data = 32'h11223344; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'h20; ar_valid = 1'b1;
      wait_accept(which, t);
      chk("arb_first_write", 64'(which), 64'(0));
      push_b(2'b00, t, 2);
      @(posedge clk); #1;
      aw_addr = 32'h24; w_data = 32'h55667788;
      wait_accept(which, t);
      chk("arb_then_read", 64'(which), 64'(1));
      push_r(2'b00, 32'h11223344, t, 3);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      wait_accept(which, t);
      chk("arb_last_write", 64'(which), 64'(0));
      push_b(2'b00, t, 2);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;

      // Full and partial writes, zero-strobe write, ignored low address bits
      do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2);
      do_read(32'h10, 32'hDEADBEEF, 2'b00, 3);
      do_write(32'h10, 32'h000000AA, 4'h1, 2'b00, 2);
      do_read(32'h10, 32'hDEADBEAA, 2'b00, 3);
      do_write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 2);
      do_read(32'h13, 32'hDEADBEAA, 2'b00, 3);

      // Range boundaries
      do_read(32'h1000, 32'h0, 2'b10, 1);
      do_write(32'h1004, 32'h12345678, 4'hF, 2'b10, 1);
      do_read(32'h8000_0010, 32'h0, 2'b10, 1);
      do_write(32'hFFC, 32'hA5A55A5A, 4'hF, 2'b00, 2);
      do_read(32'hFFC, 32'hA5A55A5A, 2'b00, 3);

      // AW without W is never accepted; B held under backpressure
      @(posedge clk); #1;
      b_ready = 1'b0;
      aw_addr = 32'h30; w_data = 32'hCAFEF00D; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b0;
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (aw_ready || w_ready) ok = 1'b0;
      end
      chk("aw_alone_not_accepted", 64'(ok), 64'(1));
      @(posedge clk); #1;
      w_valid = 1'b1;
      wait_accept(which, t);
      chk("aw_w_accepted", 64'(which), 64'(0));
      push_b(2'b00, t, 2);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      ar_addr = 32'h30; ar_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (b_valid) ok = 1'b1;
      end
      chk("bvalid_seen", 64'(ok), 64'(1));
      repeat (4) begin
         @(negedge clk);
         if (!b_valid || b_resp != 2'b00 || ar_ready) ok = 1'b0;
      end
      chk("b_hold_stable", 64'(ok), 64'(1));
      @(posedge clk); #1;
      b_ready = 1'b1;
      wait_accept(which, t);
      chk("read_after_bresp", 64'(which), 64'(1));
      push_r(2'b00, 32'hCAFEF00D, t, 3);
      @(posedge clk); #1;
      ar_valid = 1'b0;

      // Reset while in RDATA drops the read
      @(posedge clk); #1;
      ar_addr = 32'h30; ar_valid = 1'b1;
      wait_accept(which, t);
      chk("rst_read_granted", 64'(which), 64'(1));
      @(posedge clk); #1;
      ar_valid = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rdata_rst_ctrl", 64'({b_valid, r_valid, aw_ready, w_ready, ar_ready,
                                 mem_req_o, mem_we_o, b_resp, r_resp}), 64'(0));
      chk("rdata_rst_data", 64'(r_data), 64'(0));
      @(posedge clk); #1;
      rst_ni = 1'b1;
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (r_valid) ok = 1'b0;
      end
      chk("no_rvalid_after_rst", 64'(ok), 64'(1));
      do_read(32'h30, 32'hCAFEF00D, 2'b00, 3);

      repeat (10) @(negedge clk);
      chk("b_queue_drained", 64'(bq.size()), 64'(0));
      chk("r_queue_drained", 64'(rq.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
